// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared types and size helpers for the binary FC/argmax classifier
//
// Purpose: FSM state encoding, derived-size functions and the flatten-index
// rule shared by the RTL and the reference model.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } fc_state_t;

  // Length of the flattened feature vector.
  function automatic int fc_n(input int ic, input int img_size);
    return ic * img_size * img_size;
  endfunction

  // Number of chunks per pass over the feature vector.
  function automatic int fc_k(input int n, input int chunk);
    return n / chunk;
  endfunction

  // Score width: must hold 0..n inclusive.
  function automatic int fc_sw(input int n);
    return $clog2(n + 1);
  endfunction

  // Class-index width, kept at least one bit for a single-class build.
  function automatic int fc_iw(input int num_classes);
    return (num_classes > 1) ? $clog2(num_classes) : 1;
  endfunction

  // Flat bit position of pixel p of channel c.
  function automatic int flat_index(input int c, input int p, input int img_size);
    return c * img_size * img_size + p;
  endfunction

endpackage

// File: rtl/popcount_chunk.sv
// rtl/popcount_chunk.sv - combinational XNOR popcount over one chunk
//
// Purpose: counts bit positions where a_i and b_i agree.
// Ports:
//   a_i     [W-1:0]            feature chunk
//   b_i     [W-1:0]            weight chunk
//   count_o [$clog2(W+1)-1:0]  number of matching bits, 0..W
module popcount_chunk #(
  parameter int W = 28
) (
  input  logic [W-1:0]             a_i,
  input  logic [W-1:0]             b_i,
  output logic [$clog2(W+1)-1:0]   count_o
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0] match;

  assign match = ~(a_i ^ b_i);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + CW'(match[i]);
    end
  end

endmodule

// File: rtl/bnn_fc_argmax.sv
// rtl/bnn_fc_argmax.sv - sequential XNOR-popcount FC layer with argmax
//
// Purpose: flattens the binary feature maps, scores each class one chunk per
// cycle, and reports the best class (lowest index wins ties).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   data_in_ready        level; inputs valid and stable while high
//   img_in[0:IC-1]       binary feature maps, IMG_SIZE*IMG_SIZE bits each
//   weights[0:NC-1]      binary class weights, N bits each
//   class_idx            winning class (registered)
//   class_score          winning match count (registered)
//   data_out_ready       result valid (registered)
module bnn_fc_argmax
  import bnn_pkg::*;
#(
  parameter int IC          = 8,
  parameter int IMG_SIZE    = 14,
  parameter int NUM_CLASSES = 10,
  parameter int CHUNK       = 28
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   data_in_ready,
  input  logic [IMG_SIZE*IMG_SIZE-1:0]           img_in  [0:IC-1],
  input  logic [fc_n(IC, IMG_SIZE)-1:0]          weights [0:NUM_CLASSES-1],
  output logic [fc_iw(NUM_CLASSES)-1:0]          class_idx,
  output logic [fc_sw(fc_n(IC, IMG_SIZE))-1:0]   class_score,
  output logic                                   data_out_ready
);

  localparam int PIX = IMG_SIZE * IMG_SIZE;
  localparam int N   = fc_n(IC, IMG_SIZE);
  localparam int K   = fc_k(N, CHUNK);
  localparam int SW  = fc_sw(N);
  localparam int IW  = fc_iw(NUM_CLASSES);
  localparam int PW  = $clog2(CHUNK + 1);
  localparam int CW  = (K > 1) ? $clog2(K) : 1;

  if ((N % CHUNK) != 0) begin : g_chunk_check
    $error("bnn_fc_argmax: IC*IMG_SIZE*IMG_SIZE must be a multiple of CHUNK");
  end

  fc_state_t         state_q, state_d;
  logic [IW-1:0]     cls_q, cls_d;
  logic [CW-1:0]     chunk_q, chunk_d;
  logic [SW-1:0]     acc_q, acc_d;
  logic [SW-1:0]     best_score_q, best_score_d;
  logic [IW-1:0]     best_idx_q, best_idx_d;
  logic [IW-1:0]     class_idx_q, class_idx_d;
  logic [SW-1:0]     class_score_q, class_score_d;
  logic              out_ready_q, out_ready_d;

  // Flattened feature vector and the selected class's weights are pure wiring.
  logic [N-1:0]      flat;
  logic [N-1:0]      w_sel;
  logic [CHUNK-1:0]  img_slices [0:K-1];
  logic [CHUNK-1:0]  w_slices   [0:K-1];
  logic [CHUNK-1:0]  img_chunk;
  logic [CHUNK-1:0]  w_chunk;
  logic [PW-1:0]     pop;
  logic              take_new;

  for (genvar c = 0; c < IC; c++) begin : g_flat
    assign flat[flat_index(c, 0, IMG_SIZE) +: PIX] = img_in[c];
  end

  assign w_sel = weights[cls_q];

  for (genvar k = 0; k < K; k++) begin : g_slice
    assign img_slices[k] = flat[k*CHUNK +: CHUNK];
    assign w_slices[k]   = w_sel[k*CHUNK +: CHUNK];
  end

  assign img_chunk = img_slices[chunk_q];
  assign w_chunk   = w_slices[chunk_q];

  popcount_chunk #(
    .W (CHUNK)
  ) u_popcount (
    .a_i     (img_chunk),
    .b_i     (w_chunk),
    .count_o (pop)
  );

  // Strict greater-than keeps the lower index on ties; class 0 always seeds.
  assign take_new = (cls_q == '0) || (acc_q > best_score_q);

  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    chunk_d       = chunk_q;
    acc_d         = acc_q;
    best_score_d  = best_score_q;
    best_idx_d    = best_idx_q;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;
    out_ready_d   = out_ready_q;

    case (state_q)
      IDLE: begin
        if (data_in_ready) begin
          state_d = ACCUM;
          cls_d   = '0;
          chunk_d = '0;
          acc_d   = '0;
        end
      end
      ACCUM: begin
        acc_d = acc_q + SW'(pop);
        if (chunk_q == CW'(K - 1)) begin
          state_d = COMPARE;
        end else begin
          chunk_d = chunk_q + 1'b1;
        end
      end
      COMPARE: begin
        if (take_new) begin
          best_score_d = acc_q;
          best_idx_d   = cls_q;
        end
        acc_d   = '0;
        chunk_d = '0;
        if (cls_q == IW'(NUM_CLASSES - 1)) begin
          // Publish on the same edge as the final comparison.
          state_d       = DONE;
          class_idx_d   = take_new ? cls_q : best_idx_q;
          class_score_d = take_new ? acc_q : best_score_q;
          out_ready_d   = 1'b1;
        end else begin
          cls_d   = cls_q + 1'b1;
          state_d = ACCUM;
        end
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase

    // Dropping data_in_ready aborts from any state and clears everything.
    if (!data_in_ready) begin
      state_d       = IDLE;
      cls_d         = '0;
      chunk_d       = '0;
      acc_d         = '0;
      best_score_d  = '0;
      best_idx_d    = '0;
      class_idx_d   = '0;
      class_score_d = '0;
      out_ready_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cls_q         <= '0;
      chunk_q       <= '0;
      acc_q         <= '0;
      best_score_q  <= '0;
      best_idx_q    <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      out_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cls_q         <= cls_d;
      chunk_q       <= chunk_d;
      acc_q         <= acc_d;
      best_score_q  <= best_score_d;
      best_idx_q    <= best_idx_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
      out_ready_q   <= out_ready_d;
    end
  end

  assign class_idx      = class_idx_q;
  assign class_score    = class_score_q;
  assign data_out_ready = out_ready_q;

endmodule

// File: tb/tb_bnn_fc_argmax.sv
// tb/tb_bnn_fc_argmax.sv - scoreboard bench for bnn_fc_argmax
module tb_bnn_fc_argmax;

  localparam int IC    = 8;
  localparam int IMG   = 14;
  localparam int NC    = 10;
  localparam int CHUNK = 28;
  localparam int PIX   = IMG * IMG;
  localparam int N     = IC * PIX;
  localparam int LAT   = NC * (N / CHUNK + 1);
  localparam int NRAND = 100;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             din = 1'b0;
  logic [PIX-1:0]   img [0:IC-1];
  logic [N-1:0]     w   [0:NC-1];
  logic [3:0]       class_idx;
  logic [10:0]      class_score;
  logic             dout;

  typedef struct {
    int     idx;
    int     score;
    longint rise;
  } exp_t;

  exp_t   exp_q[$];
  int     errors = 0;
  int     checks = 0;
  int     results_seen = 0;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bnn_fc_argmax #(
    .IC          (IC),
    .IMG_SIZE    (IMG),
    .NUM_CLASSES (NC),
    .CHUNK       (CHUNK)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in_ready  (din),
    .img_in         (img),
    .weights        (w),
    .class_idx      (class_idx),
    .class_score    (class_score),
    .data_out_ready (dout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Reference: count agreements per class straight from the flatten rule.
  function automatic void model(output int bidx, output int bscore);
    int s;
    bidx = 0;
    bscore = 0;
    for (int j = 0; j < NC; j++) begin
      s = 0;
      for (int c = 0; c < IC; c++)
        for (int p = 0; p < PIX; p++)
          if (img[c][p] == w[j][bnn_pkg::flat_index(c, p, IMG)]) s++;
      if (j == 0 || s > bscore) begin
        bscore = s;
        bidx = j;
      end
    end
  endfunction

  function automatic logic [N-1:0] flat_img();
    logic [N-1:0] v;
    for (int c = 0; c < IC; c++)
      for (int p = 0; p < PIX; p++)
        v[bnn_pkg::flat_index(c, p, IMG)] = img[c][p];
    return v;
  endfunction

  task automatic randomize_data(input bit ties);
    for (int c = 0; c < IC; c++)
      for (int p = 0; p < PIX; p++) img[c][p] = 1'($urandom_range(0, 1));
    for (int j = 0; j < NC; j++)
      for (int f = 0; f < N; f++) w[j][f] = 1'($urandom_range(0, 1));
    if (ties)
      for (int j = 1; j < NC; j++)
        if ($urandom_range(0, 3) == 0) w[j] = w[$urandom_range(0, j - 1)];
  endtask

  task automatic wait_result(input int seen0);
    int waited = 0;
    while (results_seen == seen0 && waited < LAT + 20) begin
      @(negedge clk);
      waited++;
    end
    check("result_timeout", 64'(results_seen != seen0), 64'd1);
    if (results_seen == seen0) exp_q.delete();
  endtask

  task automatic start(input int e_idx, input int e_score);
    @(negedge clk);
    exp_q.push_back('{idx: e_idx, score: e_score, rise: cyc + 1 + LAT});
    din = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 64'(dout), 64'd0);
    check({tag, "_idx"}, 64'(class_idx), 64'd0);
    check({tag, "_score"}, 64'(class_score), 64'd0);
  endtask

  task automatic run(input int e_idx, input int e_score);
    int seen0;
    start(e_idx, e_score);
    seen0 = results_seen;
    wait_result(seen0);
    repeat (2) begin
      @(negedge clk);
      check("hold_ready", 64'(dout), 64'd1);
      check("hold_idx", 64'(class_idx), 64'(e_idx));
      check("hold_score", 64'(class_score), 64'(e_score));
    end
    din = 1'b0;
    @(negedge clk);
    check_zero("drop");
  endtask

  initial begin
    int bi, bs, seen0;
    logic [N-1:0] v;

    fork
      begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
          @(negedge clk);
          if (dout && !prev) begin
            if (exp_q.size() == 0) begin
              check("unexpected_result", 64'd1, 64'd0);
            end else begin
              e = exp_q.pop_front();
              check("class_idx", 64'(class_idx), 64'(e.idx));
              check("class_score", 64'(class_score), 64'(e.score));
              check("latency_cycle", 64'(cyc), 64'(e.rise));
            end
            results_seen++;
          end
          prev = dout;
        end
      end
    join_none

    for (int c = 0; c < IC; c++) img[c] = '0;
    for (int j = 0; j < NC; j++) w[j] = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("idle");

    // All-ones image, only class 3 all ones.
    for (int c = 0; c < IC; c++) img[c] = '1;
    for (int j = 0; j < NC; j++) w[j] = '0;
    w[3] = '1;
    run(3, N);

    // Identical weights: tie resolves to class 0.
    randomize_data(1'b0);
    for (int j = 1; j < NC; j++) w[j] = w[0];
    model(bi, bs);
    run(0, bs);

    // Classes 5 and 7 differ only inside the final chunk.
    randomize_data(1'b0);
    v = flat_img();
    for (int j = 0; j < NC; j++) w[j] = ~v;
    w[7] = v;
    w[7][1550] = ~w[7][1550];
    w[7][1560] = ~w[7][1560];
    w[5] = w[7];
    w[5][1545] = ~w[5][1545];
    run(7, N - 2);

    // Abort at cycle 200, then a clean rerun.
    randomize_data(1'b1);
    model(bi, bs);
    @(negedge clk);
    din = 1'b1;
    repeat (200) @(negedge clk);
    din = 1'b0;
    @(negedge clk);
    check_zero("abort");
    run(bi, bs);

    // Asynchronous reset mid-accumulation.
    randomize_data(1'b1);
    model(bi, bs);
    @(negedge clk);
    din = 1'b1;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_accum");
    din = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(bi, bs);

    // Asynchronous reset while a result is being held.
    randomize_data(1'b1);
    model(bi, bs);
    start(bi, bs);
    seen0 = results_seen;
    wait_result(seen0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_done");
    din = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(bi, bs);

    // Randomized runs with injected ties.
    for (int r = 0; r < NRAND; r++) begin
      randomize_data(1'b1);
      model(bi, bs);
      run(bi, bs);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
